final_permutation_serializer: RTL and testbench
===============================================

# final_permutation_serializer

Output stage of the DES datapath. Accepts the 32-bit LEFT/RIGHT halves produced after round 16, applies the round swap and the inverse initial permutation (IP⁻¹, exact inverse of the Initial_Permutation mapping), and streams the 64-bit cipher block out as eight bytes over a valid/ready interface. Contains a one-block holding register, so a new block can be accepted while the previous one is still being shifted out.

## Interface
- No parameters. Widths fixed: 32-bit halves, 64-bit block, 8-bit output byte.
- CLK  input  1  clock, rising edge.
- RESET_BAR  input  1  asynchronous, active-low reset.
- CHIP_SELECT_BAR  input  1  0 = block enabled; 1 = handshakes frozen.
- ROUND_SWAP  input  1  1 = swap halves (normal, after round 16); 0 = no swap (loopback test). Sampled with the block.
- LEFT  input  [32:1]  left half from the last round.
- RIGHT  input  [32:1]  right half from the last round.
- IN_VALID  input  1  LEFT/RIGHT/ROUND_SWAP are valid.
- IN_READY  output  1  block can be accepted.
- OUT_BYTE  output  [8:1]  cipher byte, most significant first.
- OUT_VALID  output  1  OUT_BYTE is valid.
- OUT_READY  input  1  consumer takes OUT_BYTE.
- OUT_LAST  output  1  high with the eighth byte of a block.

## Operation
- Pre-output X[64:1]: ROUND_SWAP=1 → X[64:33]=RIGHT, X[32:1]=LEFT; ROUND_SWAP=0 → X[64:33]=LEFT, X[32:1]=RIGHT.
- IP⁻¹: CIPHER[IP_TABLE[n]] = X[n] for n=1..64, where IP_TABLE is the Initial_Permutation table (IP_TABLE[1]=58, [2]=50, … [64]=7). Bit k of [64:1] carries weight 2^(k-1).
- Storage: SHIFT_REG[64:1] (active block), HOLD_REG[64:1] + HOLD_FULL, BYTE_CNT[3:0].
- States: IDLE (SHIFT_REG empty) and SHIFT (bytes pending).
- IN_READY = !CHIP_SELECT_BAR && !HOLD_FULL.
- Accept (IN_VALID && IN_READY at edge): if IDLE, or SHIFT with final-byte handshake on the same edge and HOLD_FULL=0 → load CIPHER directly into SHIFT_REG, BYTE_CNT=0, state SHIFT. Otherwise → HOLD_REG, HOLD_FULL=1.
- OUT_BYTE = SHIFT_REG[64:57]; OUT_VALID = (state==SHIFT) && !CHIP_SELECT_BAR; OUT_LAST = OUT_VALID && BYTE_CNT==7.
- Byte handshake (OUT_VALID && OUT_READY): SHIFT_REG shifts left 8, BYTE_CNT+1. On the 8th byte: if HOLD_FULL → SHIFT_REG=HOLD_REG, BYTE_CNT=0, HOLD_FULL=0, stay SHIFT; else → IDLE.
- CHIP_SELECT_BAR=1: no handshake completes, all state held; outputs driven (never Z), valid/ready low.
- OUT_BYTE is undefined-but-stable (SHIFT_REG contents) when OUT_VALID=0; verification does not check it.

## Timing
- Reset (RESET_BAR low, asynchronous): state IDLE, SHIFT_REG=0, HOLD_REG=0, HOLD_FULL=0, BYTE_CNT=0 → OUT_BYTE=8'h00, OUT_VALID=0, OUT_LAST=0, IN_READY=!CHIP_SELECT_BAR. Deassertion mid-block discards all pending data.
- Latency: block accepted at edge t while IDLE → first byte valid after edge t (cycle t+1).
- Throughput: 8 cycles/block with OUT_READY held high; no bubble between back-to-back blocks.
- Back-pressure: OUT_READY low holds OUT_BYTE/OUT_VALID/OUT_LAST stable.
- Full: SHIFT active + HOLD_FULL → IN_READY=0 until the final-byte handshake edge; IN_READY rises the cycle after.
- BYTE_CNT never exceeds 7 while in SHIFT; wraps to 0 on every block load.

## Structure
- Shared package des_pkg: IP_TABLE[1..64] constant (shared with Initial_Permutation), DES_BLOCK_W=64, DES_HALF_W=32, state enum {IDLE, SHIFT}.
- Sub-module inverse_permutation: combinational swap + IP⁻¹ (LEFT, RIGHT, ROUND_SWAP → CIPHER[64:1]). Top holds the FSM, registers and handshakes.

## Test plan
- Single bit, ROUND_SWAP=0, LEFT=0, RIGHT=32'h1 → CIPHER=64'h0200_0000_0000_0000; bytes 02,00,00,00,00,00,00,00, OUT_LAST on the 8th only; first byte the cycle after accept.
- Same block with ROUND_SWAP=1, LEFT=32'h1, RIGHT=0 → identical byte stream.
- Loopback: 64'h0123_4567_89AB_CDEF through Initial_Permutation, then this block with ROUND_SWAP=0 → bytes 01,23,45,67,89,AB,CD,EF.
- Three blocks, IN_VALID and OUT_READY held high → 24 bytes in consecutive cycles, IN_READY low while hold is full, no bubbles.
- Random OUT_READY back-pressure plus CHIP_SELECT_BAR=1 for 5 cycles mid-block → output stalls and stays stable, stream matches reference model byte-for-byte.
- RESET_BAR pulsed low after byte 3 with a held block pending → all outputs at reset values immediately; next accepted block streams cleanly from byte 1.

Source files
------------

// File: rtl/des_pkg.sv
// Constants and types shared across the DES datapath stages.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_HALF_W  = 32;
  localparam int DES_BYTE_W  = 8;
  localparam int DES_BYTES   = DES_BLOCK_W / DES_BYTE_W;

  // Initial_Permutation source-bit table, indexed 1..64.
  localparam int IP_TABLE [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/inverse_permutation.sv
// Round swap followed by IP^-1; purely combinational.
module inverse_permutation
  import des_pkg::*;
(
  input  logic [DES_HALF_W:1]  left,
  input  logic [DES_HALF_W:1]  right,
  input  logic                 round_swap,
  output logic [DES_BLOCK_W:1] cipher
);

  logic [DES_BLOCK_W:1] x;

  assign x = round_swap ? {right, left} : {left, right};

  // IP scatters bit IP_TABLE[n] to position n, so the inverse gathers it back.
  for (genvar n = 1; n <= DES_BLOCK_W; n++) begin : g_perm
    assign cipher[IP_TABLE[n]] = x[n];
  end

endmodule

// File: rtl/final_permutation_serializer.sv
// DES output stage: swap + IP^-1, then byte-serial streaming with a one-block hold buffer.
//
// state | meaning
// IDLE  | shift register empty, nothing to send
// SHIFT | shift register holds a block, bytes pending
module final_permutation_serializer
  import des_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET_BAR,
  input  logic                CHIP_SELECT_BAR,
  input  logic                ROUND_SWAP,
  input  logic [DES_HALF_W:1] LEFT,
  input  logic [DES_HALF_W:1] RIGHT,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [DES_BYTE_W:1] OUT_BYTE,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                OUT_LAST
);

  state_e               state, state_next;
  logic [DES_BLOCK_W:1] shift_reg, shift_next;
  logic [DES_BLOCK_W:1] hold_reg, hold_next;
  logic                 hold_full, hold_full_next;
  logic [3:0]           byte_cnt, byte_cnt_next;
  logic [DES_BLOCK_W:1] cipher;

  logic enabled;
  logic in_fire;
  logic out_fire;
  logic last_fire;

  inverse_permutation u_inverse_permutation (
    .left       (LEFT),
    .right      (RIGHT),
    .round_swap (ROUND_SWAP),
    .cipher     (cipher)
  );

  assign enabled   = !CHIP_SELECT_BAR;
  assign IN_READY  = enabled && !hold_full;
  assign OUT_VALID = (state == SHIFT) && enabled;
  assign OUT_LAST  = OUT_VALID && (byte_cnt == 4'd7);
  assign OUT_BYTE  = shift_reg[DES_BLOCK_W:DES_BLOCK_W-DES_BYTE_W+1];

  assign in_fire   = IN_VALID && IN_READY;
  assign out_fire  = OUT_VALID && OUT_READY;
  assign last_fire = out_fire && (byte_cnt == 4'd7);

  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      hold_reg  <= hold_next;
      hold_full <= hold_full_next;
      byte_cnt  <= byte_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full;
    byte_cnt_next  = byte_cnt;

    if (out_fire) begin
      shift_next    = {shift_reg[DES_BLOCK_W-DES_BYTE_W:1], {DES_BYTE_W{1'b0}}};
      byte_cnt_next = byte_cnt + 4'd1;
      if (last_fire) begin
        if (hold_full) begin
          shift_next     = hold_reg;
          byte_cnt_next  = '0;
          hold_full_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
    end

    // in_fire implies hold_full==0, so a last-byte edge always frees the shifter.
    if (in_fire) begin
      if (state == IDLE || last_fire) begin
        shift_next    = cipher;
        byte_cnt_next = '0;
        state_next    = SHIFT;
      end else begin
        hold_next      = cipher;
        hold_full_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_final_permutation_serializer.sv
// Self-checking bench: table vectors, directed corner sequences and a queue-based reference model.
module tb_final_permutation_serializer;

  logic        CLK = 1'b0;
  logic        RESET_BAR = 1'b0;
  logic        CHIP_SELECT_BAR = 1'b0;
  logic        ROUND_SWAP = 1'b0;
  logic [32:1] LEFT = '0;
  logic [32:1] RIGHT = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [8:1]  OUT_BYTE;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic        OUT_LAST;

  final_permutation_serializer dut (
    .CLK             (CLK),
    .RESET_BAR       (RESET_BAR),
    .CHIP_SELECT_BAR (CHIP_SELECT_BAR),
    .ROUND_SWAP      (ROUND_SWAP),
    .LEFT            (LEFT),
    .RIGHT           (RIGHT),
    .IN_VALID        (IN_VALID),
    .IN_READY        (IN_READY),
    .OUT_BYTE        (OUT_BYTE),
    .OUT_VALID       (OUT_VALID),
    .OUT_READY       (OUT_READY),
    .OUT_LAST        (OUT_LAST)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int ip_tab [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  // Reference model: FIFO of whole cipher blocks (at most two) and the byte position in the head.
  logic [63:0] blk_q[$];
  int          pos = 0;
  int          nbytes = 0;

  function automatic logic [63:0] ip_fwd(input logic [63:0] p);
    logic [63:0] x = '0;
    for (int n = 0; n < 64; n++) x[n] = p[ip_tab[n] - 1];
    return x;
  endfunction

  function automatic logic [63:0] ip_inv(input logic [31:0] l, input logic [31:0] r, input logic sw);
    logic [63:0] x = sw ? {r, l} : {l, r};
    logic [63:0] c = '0;
    for (int n = 0; n < 64; n++)
      if (x[n]) c = c | (64'd1 << (ip_tab[n] - 1));
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic        ev, er;
    logic [63:0] head;
    logic [7:0]  eb;
    ev = !CHIP_SELECT_BAR && (blk_q.size() > 0);
    er = !CHIP_SELECT_BAR && (blk_q.size() < 2);
    chk("out_valid", OUT_VALID, ev);
    chk("in_ready", IN_READY, er);
    chk("out_last", OUT_LAST, ev && pos == 7);
    if (ev) begin
      head = blk_q[0];
      eb = head[63 - 8*pos -: 8];
      chk("out_byte", OUT_BYTE, eb);
    end
  endtask

  task automatic tick();
    logic        ofire, ifire;
    logic [63:0] c;
    ofire = !CHIP_SELECT_BAR && blk_q.size() > 0 && OUT_READY;
    ifire = !CHIP_SELECT_BAR && blk_q.size() < 2 && IN_VALID;
    c = ip_inv(LEFT, RIGHT, ROUND_SWAP);
    @(posedge CLK);
    if (ofire) begin
      nbytes++;
      pos++;
      if (pos == 8) begin
        void'(blk_q.pop_front());
        pos = 0;
      end
    end
    if (ifire) blk_q.push_back(c);
    #1;
    check_outputs();
  endtask

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic        sw;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic stream_check(input string name, input logic [63:0] exp_blk);
    logic [7:0] eb;
    for (int i = 0; i < 8; i++) begin
      eb = exp_blk[63 - 8*i -: 8];
      chk({name, "_byte"}, OUT_BYTE, eb);
      chk({name, "_valid"}, OUT_VALID, 1'b1);
      chk({name, "_last"}, OUT_LAST, i == 7);
      tick();
    end
    chk({name, "_idle_after"}, OUT_VALID, 1'b0);
  endtask

  initial begin
    logic [63:0] lb;
    logic [63:0] saved;
    int          accepted;
    bit          saw_full;
    int          n0;

    lb = ip_fwd(64'h0123_4567_89AB_CDEF);
    vecs[0] = '{32'h0, 32'h1, 1'b0, 64'h0200_0000_0000_0000};
    vecs[1] = '{32'h1, 32'h0, 1'b1, 64'h0200_0000_0000_0000};
    vecs[2] = '{lb[63:32], lb[31:0], 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{32'h0, 32'h2, 1'b0, 64'h0002_0000_0000_0000};
    vecs[4] = '{32'h1, 32'h0, 1'b0, 64'h0100_0000_0000_0000};

    #2;
    chk("rst_out_byte", OUT_BYTE, 8'h00);
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_out_last", OUT_LAST, 1'b0);
    chk("rst_in_ready", IN_READY, 1'b1);
    CHIP_SELECT_BAR = 1'b1;
    #1;
    chk("rst_in_ready_csb", IN_READY, 1'b0);
    CHIP_SELECT_BAR = 1'b0;
    #1;
    RESET_BAR = 1'b1;
    tick();

    // Table vectors: accept, then first byte must be valid the very next cycle.
    OUT_READY = 1'b1;
    foreach (vecs[k]) begin
      LEFT = vecs[k].l; RIGHT = vecs[k].r; ROUND_SWAP = vecs[k].sw; IN_VALID = 1'b1;
      chk("vec_idle_before", OUT_VALID, 1'b0);
      tick();
      IN_VALID = 1'b0;
      stream_check($sformatf("vec%0d", k), vecs[k].exp);
    end

    // Three back-to-back blocks with IN_VALID and OUT_READY high: 24 bytes, no bubbles.
    accepted = 0;
    saw_full = 0;
    n0 = nbytes;
    LEFT = $urandom; RIGHT = $urandom; ROUND_SWAP = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (IN_VALID && IN_READY) accepted++;
      tick();
      if (!IN_READY) saw_full = 1;
      if (accepted == 3) IN_VALID = 1'b0;
      else begin LEFT = $urandom; RIGHT = $urandom; end
    end
    chk("b2b_bytes", nbytes - n0, 24);
    chk("b2b_saw_full", saw_full, 1'b1);
    chk("b2b_drained", OUT_VALID, 1'b0);

    // Random traffic with back-pressure and a 5-cycle chip-select freeze mid-block.
    for (int i = 0; i < 400; i++) begin
      OUT_READY  = ($urandom_range(0, 3) != 0);
      IN_VALID   = ($urandom_range(0, 2) == 0);
      LEFT       = $urandom;
      RIGHT      = $urandom;
      ROUND_SWAP = $urandom_range(0, 1);
      if (i == 150) begin
        while (!(OUT_VALID && pos > 0 && pos < 7)) begin
          IN_VALID = 1'b1; OUT_READY = 1'b1;
          tick();
        end
        saved = {56'h0, OUT_BYTE};
        CHIP_SELECT_BAR = 1'b1;
        for (int j = 0; j < 5; j++) begin
          OUT_READY = 1'b1; IN_VALID = 1'b1;
          tick();
          chk("csb_byte_stable", OUT_BYTE, saved);
        end
        CHIP_SELECT_BAR = 1'b0;
        #1;
        check_outputs();
      end
      tick();
    end

    // Drain, then reset mid-block with a held block pending.
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    LEFT = 32'hDEAD_BEEF; RIGHT = 32'h1234_5678; ROUND_SWAP = 1'b1; IN_VALID = 1'b1;
    tick();
    LEFT = 32'hCAFE_F00D; RIGHT = 32'h0BAD_C0DE;
    tick();
    IN_VALID = 1'b0;
    tick();
    tick();
    chk("pre_rst_hold_full", IN_READY, 1'b0);
    chk("pre_rst_pos", pos, 3);
    RESET_BAR = 1'b0;
    #1;
    chk("midrst_out_byte", OUT_BYTE, 8'h00);
    chk("midrst_out_valid", OUT_VALID, 1'b0);
    chk("midrst_out_last", OUT_LAST, 1'b0);
    chk("midrst_in_ready", IN_READY, 1'b1);
    blk_q.delete();
    pos = 0;
    #1;
    RESET_BAR = 1'b1;
    tick();
    chk("post_rst_idle", OUT_VALID, 1'b0);
    LEFT = vecs[2].l; RIGHT = vecs[2].r; ROUND_SWAP = vecs[2].sw; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    stream_check("post_rst", vecs[2].exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
